uart_tx_arbiter: RTL and testbench

//  Round-robin, packet-aware arbiter that shares one UART transmitter among NUM_SOURCES byte streams.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : packet-aware round-robin arbiter sharing one UART tx stream
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SOURCES-1:0]            s_tvalid,
    input  logic [NUM_SOURCES-1:0]            s_tlast,
    output logic [NUM_SOURCES-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic                              busy
);
    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [NUM_SOURCES-1:0] grant_q;
    logic                   busy_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       last_idx_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [CNT_W-1:0]       beat_cnt_d;

    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [IDX_W-1:0]       w_cand;
    logic                   w_accept;
    logic                   w_burst_hit;
    logic                   w_release;

    // Walk from the farthest candidate back to last_idx+1 so the nearest valid one wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = NUM_SOURCES; k >= 1; k--) begin
            w_cand = IDX_W'((int'(last_idx_q) + k) % NUM_SOURCES);
            if (s_tvalid[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant_q[i]) begin
                m_tdata  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_tvalid = s_tvalid[i];
                m_tlast  = s_tlast[i];
            end
        end
    end

    assign s_tready = grant_q & {NUM_SOURCES{m_tready}};
    assign grant    = grant_q;
    assign busy     = busy_q;

    assign w_accept  = (state_q == S_LOCKED) && m_tvalid && m_tready;
    assign w_release = m_tlast || w_burst_hit;

    generate
        if (MAX_BURST > 0) begin : g_burst
            assign w_burst_hit = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
            assign beat_cnt_d  = beat_cnt_q + 1'b1;
        end else begin : g_no_burst
            // Counter is never advanced, so it stays at its reset value of zero.
            assign w_burst_hit = 1'b0;
            assign beat_cnt_d  = beat_cnt_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            last_idx_q <= IDX_W'(NUM_SOURCES - 1);
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        state_q <= S_LOCKED;
                        grant_q <= NUM_SOURCES'(1) << w_pick_idx;
                        busy_q  <= 1'b1;
                        owner_q <= w_pick_idx;
                    end
                end
                S_LOCKED: begin
                    if (w_accept) begin
                        if (w_release) begin
                            state_q    <= S_IDLE;
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            last_idx_q <= owner_q;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : bench for uart_tx_arbiter (unlimited and MAX_BURST=4 builds)
// Revision 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic        m_tready;

    logic [3:0]  st_rdy   [2];
    logic [7:0]  mt_data  [2];
    logic        mt_valid [2];
    logic        mt_last  [2];
    logic [3:0]  gnt      [2];
    logic        bsy      [2];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(8), .MAX_BURST(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(st_rdy[0]), .m_tdata(mt_data[0]),
        .m_tvalid(mt_valid[0]), .m_tlast(mt_last[0]), .m_tready(m_tready),
        .grant(gnt[0]), .busy(bsy[0]));

    uart_tx_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(st_rdy[1]), .m_tdata(mt_data[1]),
        .m_tvalid(mt_valid[1]), .m_tlast(mt_last[1]), .m_tready(m_tready),
        .grant(gnt[1]), .busy(bsy[1]));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when nobody holds the stream), previous owner, beats in grant.
    int md_own  [2];
    int md_last [2];
    int md_cnt  [2];
    int mg;

    function automatic int burst_of(int k);
        return (k == 0) ? 0 : 4;
    endfunction

    function automatic int rr_pick(int last, logic [3:0] v);
        for (int j = 1; j <= 4; j++) begin
            if (v[(last + j) % 4]) return (last + j) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                md_own[k]  <= -1;
                md_last[k] <= 3;
                md_cnt[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (md_own[k] < 0) begin
                    md_own[k] <= rr_pick(md_last[k], s_tvalid);
                end else if (s_tvalid[md_own[k]] && m_tready) begin
                    if (s_tlast[md_own[k]] || (burst_of(k) > 0 && md_cnt[k] + 1 == burst_of(k))) begin
                        md_own[k]  <= -1;
                        md_last[k] <= md_own[k];
                        md_cnt[k]  <= 0;
                    end else begin
                        md_cnt[k] <= md_cnt[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (md_own[k] < 0) begin
                    chk("mdl_idle_grant", k, 32'(gnt[k]), 32'h0);
                    chk("mdl_idle_busy", k, 32'(bsy[k]), 32'h0);
                    chk("mdl_idle_mvalid", k, 32'(mt_valid[k]), 32'h0);
                    chk("mdl_idle_sready", k, 32'(st_rdy[k]), 32'h0);
                end else begin
                    mg = md_own[k];
                    chk("mdl_grant", k, 32'(gnt[k]), 32'(1) << mg);
                    chk("mdl_busy", k, 32'(bsy[k]), 32'h1);
                    chk("mdl_mvalid", k, 32'(mt_valid[k]), 32'(s_tvalid[mg]));
                    chk("mdl_mdata", k, 32'(mt_data[k]), 32'(s_tdata[mg*8 +: 8]));
                    chk("mdl_mlast", k, 32'(mt_last[k]), 32'(s_tlast[mg]));
                    chk("mdl_sready", k, 32'(st_rdy[k]), m_tready ? (32'(1) << mg) : 32'h0);
                end
            end
        end
    end

    // Queue-driven byte sources: mem holds {tlast, tdata}, rd/wr wrap naturally at 64.
    logic [8:0] mem [4][64];
    logic [5:0] rd  [4];
    logic [5:0] wr  [4];
    logic [3:0] src_en;
    bit         gen_en;
    bit         rnd;
    int         fol;
    int         open_src;
    int         log_n;
    int         log_src [8192];
    logic [7:0] log_dat [8192];

    task automatic push(int i, logic [7:0] d, logic l);
        mem[i][wr[i]] = {l, d};
        wr[i] = wr[i] + 6'd1;
    endtask

    task automatic drive();
        logic [5:0]  occ;
        int          len;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        if (rnd) begin
            m_tready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                src_en[i] = ($urandom_range(0, 4) != 0);
                occ = wr[i] - rd[i];
                if (occ < 6'd8 && $urandom_range(0, 5) == 0) begin
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
        end
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (wr[i] != rd[i]) begin
                v[i]         = src_en[i];
                l[i]         = mem[i][rd[i]][8];
                d[i*8 +: 8]  = mem[i][rd[i]][7:0];
            end
        end
        s_tvalid = v;
        s_tlast  = l;
        s_tdata  = d;
    endtask

    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = s_tvalid & st_rdy[fol];
        if (gen_en) begin
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    chk("sb_data", fol, 32'(mt_data[fol]), 32'(mem[i][rd[i]][7:0]));
                    chk("sb_last", fol, 32'(mt_last[fol]), 32'(mem[i][rd[i]][8]));
                    if (fol == 0 && open_src >= 0) chk("no_interleave", fol, i, open_src);
                    open_src = mt_last[fol] ? -1 : i;
                    if (log_n < 8192) begin
                        log_src[log_n] = i;
                        log_dat[log_n] = mt_data[fol];
                        log_n++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (gen_en) begin
            for (int i = 0; i < 4; i++) if (hs[i]) rd[i] = rd[i] + 6'd1;
            drive();
        end
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            rd[i] = '0;
            wr[i] = '0;
        end
        src_en   = 4'hF;
        log_n    = 0;
        open_src = -1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        rnd      = 1'b0;
        m_tready = 1'b1;
        flush();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_log(string name, int n, int budget);
        for (int c = 0; c < budget && log_n < n; c++) tick();
        chk(name, fol, 32'(log_n >= n), 32'h1);
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  e_gnt;
        logic        e_mvalid;
        logic [7:0]  e_mdata;
        logic        e_mlast;
        logic        e_busy;
    } vec_t;

    vec_t tv [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{4'b0100, 4'b0000, 32'h0041_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1] = '{4'b0100, 4'b0000, 32'h0041_0000, 1'b1, 4'b0100, 1'b1, 8'h41, 1'b0, 1'b1};
        tv[2] = '{4'b0100, 4'b0000, 32'h0042_0000, 1'b1, 4'b0100, 1'b1, 8'h42, 1'b0, 1'b1};
        tv[3] = '{4'b0100, 4'b0100, 32'h0043_0000, 1'b1, 4'b0100, 1'b1, 8'h43, 1'b1, 1'b1};
        tv[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};

        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        gen_en   = 1'b1;
        fol      = 0;
        chk_en   = 1'b1;
        do_reset();

        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", k, 32'(gnt[k]), 32'h0);
            chk("rst_busy", k, 32'(bsy[k]), 32'h0);
            chk("rst_mvalid", k, 32'(mt_valid[k]), 32'h0);
            chk("rst_sready", k, 32'(st_rdy[k]), 32'h0);
        end

        // Source 2 sends 0x41,0x42,0x43 with the stream always ready.
        gen_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_tvalid = tv[i].vld;
            s_tlast  = tv[i].lst;
            s_tdata  = tv[i].dat;
            m_tready = tv[i].rdy;
            #1;
            chk("t1_grant", 0, 32'(gnt[0]), 32'(tv[i].e_gnt));
            chk("t1_busy", 0, 32'(bsy[0]), 32'(tv[i].e_busy));
            chk("t1_mvalid", 0, 32'(mt_valid[0]), 32'(tv[i].e_mvalid));
            chk("t1_sready", 0, 32'(st_rdy[0]), 32'(tv[i].e_gnt & {4{tv[i].rdy}}));
            if (tv[i].e_mvalid) begin
                chk("t1_mdata", 0, 32'(mt_data[0]), 32'(tv[i].e_mdata));
                chk("t1_mlast", 0, 32'(mt_last[0]), 32'(tv[i].e_mlast));
            end
            tick();
        end
        gen_en = 1'b1;

        // All four sources with 2-byte packets: served 0,1,2,3 without interleaving.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(i, 8'(i * 16 + 1), 1'b0);
            push(i, 8'(i * 16 + 2), 1'b1);
        end
        wait_log("t2_done", 8, 60);
        for (int k = 0; k < 8; k++) begin
            chk("t2_order", 0, log_src[k], k / 2);
            chk("t2_data", 0, 32'(log_dat[k]), (k / 2) * 16 + 1 + (k % 2));
        end

        // Owner 1 stalls mid-packet while source 0 waits.
        do_reset();
        for (int b = 0; b < 5; b++) push(1, 8'(8'h11 + b), b == 4);
        wait_log("t3_start", 2, 20);
        src_en[1] = 1'b0;
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold", 0, 32'(gnt[0]), 32'h2);
        end
        src_en[1] = 1'b1;
        wait_log("t3_done", 7, 30);
        for (int k = 0; k < 7; k++) chk("t3_order", 0, log_src[k], (k < 5) ? 1 : 0);

        // Burst limit of 4: source 0 has 10 unterminated bytes, source 3 a 2-byte packet.
        do_reset();
        fol = 1;
        for (int b = 0; b < 10; b++) push(0, 8'(b), 1'b0);
        push(3, 8'hA0, 1'b0);
        push(3, 8'hA1, 1'b1);
        wait_log("t4_done", 12, 60);
        for (int k = 0; k < 12; k++) begin
            chk("t4_src", 1, log_src[k], (k >= 4 && k < 6) ? 3 : 0);
            chk("t4_data", 1, 32'(log_dat[k]),
                (k < 4) ? k : ((k < 6) ? (32'hA0 + k - 4) : (k - 2)));
        end
        fol = 0;

        // Backpressure 1,0,0,1 mid-packet: nothing lost, nothing repeated.
        do_reset();
        for (int b = 0; b < 4; b++) push(2, 8'(8'h51 + b), b == 3);
        for (int c = 0; c < 10 && !bsy[0]; c++) tick();
        chk("t5_grant", 0, 32'(gnt[0]), 32'h4);
        push(1, 8'h61, 1'b1);
        for (int p = 0; p < 4; p++) begin
            m_tready = (p == 0 || p == 3);
            #1;
            chk("t5_sready", 0, 32'(st_rdy[0]), m_tready ? 32'h4 : 32'h0);
            tick();
        end
        m_tready = 1'b1;
        wait_log("t5_done", 5, 20);
        for (int k = 0; k < 5; k++) begin
            chk("t5_src", 0, log_src[k], (k < 4) ? 2 : 1);
            chk("t5_data", 0, 32'(log_dat[k]), (k < 4) ? (32'h51 + k) : 32'h61);
        end

        // Asynchronous reset in the middle of a packet from source 1.
        do_reset();
        for (int b = 0; b < 4; b++) push(1, 8'(8'h71 + b), b == 3);
        wait_log("t6_start", 1, 10);
        #1;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_grant", k, 32'(gnt[k]), 32'h0);
            chk("t6_busy", k, 32'(bsy[k]), 32'h0);
            chk("t6_mvalid", k, 32'(mt_valid[k]), 32'h0);
            chk("t6_sready", k, 32'(st_rdy[k]), 32'h0);
        end
        flush();
        tick();
        reset_n = 1'b1;
        push(0, 8'h81, 1'b1);
        push(1, 8'h91, 1'b1);
        tick();
        tick();
        chk("t6_prio", 0, 32'(gnt[0]), 32'h1);
        wait_log("t6_done", 2, 20);
        chk("t6_first", 0, log_src[0], 0);
        chk("t6_second", 0, log_src[1], 1);

        // Randomized traffic against the model, following each build in turn.
        for (int f = 0; f < 2; f++) begin
            do_reset();
            fol = f;
            rnd = 1'b1;
            for (int c = 0; c < 2000; c++) tick();
            chk("rnd_activity", f, 32'(log_n > 100), 32'h1);
        end
        rnd = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
